// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters.
// Zero-latency lookup for the fetch PC, training from the EX-stage resolved
// outcome, combinational mispredict/redirect, and branch statistics.
module branch_predictor #(
    parameter int IDX_W = 6,
    parameter int TAG_W = 32 - IDX_W - 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_if,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] br_cnt,
    output logic [31:0] mispred_cnt
);
    localparam int ENTRIES = 1 << IDX_W;

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    logic [IDX_W-1:0] idx, uidx;
    logic [TAG_W-1:0] ltag, utag;
    logic             hit, uhit;

    // Word-aligned PCs: the low two bits never select an entry.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{pc_if[1:0], ex_pc[1:0]};

    assign idx  = pc_if[IDX_W+1:2];
    assign ltag = pc_if[31:IDX_W+2];
    assign uidx = ex_pc[IDX_W+1:2];
    assign utag = ex_pc[31:IDX_W+2];

    // Fetch-side lookup; reads pre-edge contents (no bypass from training).
    always_comb begin
        hit         = valid[idx] && (tag_q[idx] == ltag);
        pred_taken  = hit && ctr_q[idx][1];
        pred_target = pred_taken ? target_q[idx] : pc_if + 32'd4;
    end

    // Mispredict detection and recovery PC for the EX-stage branch.
    always_comb begin
        mispredict  = upd_valid &&
                      ((ex_pred_taken != ex_taken) ||
                       (ex_taken && (ex_pred_target != ex_target)));
        redirect_pc = ex_taken ? ex_target : ex_pc + 32'd4;
    end

    assign uhit = valid[uidx] && (tag_q[uidx] == utag);

    // Table training: counters move on hits, taken misses allocate at weakly-taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (upd_valid) begin
            if (uhit) begin
                if (ex_taken) begin
                    if (ctr_q[uidx] != 2'b11) ctr_q[uidx] <= ctr_q[uidx] + 2'd1;
                    target_q[uidx] <= ex_target;
                end else if (ctr_q[uidx] != 2'b00) begin
                    ctr_q[uidx] <= ctr_q[uidx] - 2'd1;
                end
            end else if (ex_taken) begin
                valid[uidx]    <= 1'b1;
                tag_q[uidx]    <= utag;
                target_q[uidx] <= ex_target;
                ctr_q[uidx]    <= 2'b10;
            end
        end
    end

    // Statistics counters; free-running, wrap at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt      <= '0;
            mispred_cnt <= '0;
        end else if (upd_valid) begin
            br_cnt <= br_cnt + 32'd1;
            if (mispredict) mispred_cnt <= mispred_cnt + 32'd1;
        end
    end
endmodule
